// File: rtl/arcade_input_pkg.sv
// Keycodes, joystick bit positions and per-player key slot layout shared by the
// arcade input mapper and its bench.
package arcade_input_pkg;

    localparam logic [8:0] KEY_P1_UP    = 9'h175;
    localparam logic [8:0] KEY_P1_DOWN  = 9'h172;
    localparam logic [8:0] KEY_P1_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_P1_RIGHT = 9'h174;
    localparam logic [8:0] KEY_P1_FIRE0 = 9'h014;
    localparam logic [8:0] KEY_P1_FIRE1 = 9'h011;
    localparam logic [8:0] KEY_P1_FIRE2 = 9'h029;
    localparam logic [8:0] KEY_P1_FIRE3 = 9'h012;
    localparam logic [8:0] KEY_P1_START = 9'h016;
    localparam logic [8:0] KEY_P1_COIN  = 9'h02E;

    localparam logic [8:0] KEY_P2_UP    = 9'h02D;
    localparam logic [8:0] KEY_P2_DOWN  = 9'h02B;
    localparam logic [8:0] KEY_P2_LEFT  = 9'h023;
    localparam logic [8:0] KEY_P2_RIGHT = 9'h034;
    localparam logic [8:0] KEY_P2_FIRE0 = 9'h01C;
    localparam logic [8:0] KEY_P2_FIRE1 = 9'h01B;
    localparam logic [8:0] KEY_P2_FIRE2 = 9'h015;
    localparam logic [8:0] KEY_P2_FIRE3 = 9'h01D;
    localparam logic [8:0] KEY_P2_START = 9'h01E;
    localparam logic [8:0] KEY_P2_COIN  = 9'h036;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_BTN0  = 4;

    // Held-key slots follow the joystick order; all four fire slots always exist.
    localparam int SLOT_START = 8;
    localparam int SLOT_COIN  = 9;
    localparam int NUM_SLOTS  = 10;

    // Joystick index of start (coin = 0) or coin (coin = 1).
    function automatic int joy_aux_idx(input int num_buttons, input logic coin);
        return JOY_BTN0 + num_buttons + (coin ? 1 : 0);
    endfunction

    function automatic logic [8:0] key_code(input int player, input int slot);
        logic [8:0] code;
        code = 9'h000;
        if (player == 0) begin
            case (slot)
                0: code = KEY_P1_RIGHT;
                1: code = KEY_P1_LEFT;
                2: code = KEY_P1_DOWN;
                3: code = KEY_P1_UP;
                4: code = KEY_P1_FIRE0;
                5: code = KEY_P1_FIRE1;
                6: code = KEY_P1_FIRE2;
                7: code = KEY_P1_FIRE3;
                8: code = KEY_P1_START;
                default: code = KEY_P1_COIN;
            endcase
        end else begin
            case (slot)
                0: code = KEY_P2_RIGHT;
                1: code = KEY_P2_LEFT;
                2: code = KEY_P2_DOWN;
                3: code = KEY_P2_UP;
                4: code = KEY_P2_FIRE0;
                5: code = KEY_P2_FIRE1;
                6: code = KEY_P2_FIRE2;
                7: code = KEY_P2_FIRE3;
                8: code = KEY_P2_START;
                default: code = KEY_P2_COIN;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/coin_stretch.sv
// Stretches a coin input so the registered output stays high at least PULSE cycles.
module coin_stretch #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] PULSE = WIDTH'(48000)
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic [WIDTH-1:0] count_reg;
    logic             in_reg;
    logic             rise;

    assign rise = in & ~in_reg;

    // The output uses the count before this edge's update, so a load of PULSE-1
    // yields exactly PULSE high cycles including the edge cycle.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            in_reg    <= 1'b0;
            out       <= 1'b0;
        end else begin
            in_reg <= in;
            out    <= in | (count_reg != '0);
            if (rise)
                count_reg <= PULSE - WIDTH'(1);
            else if (count_reg != '0)
                count_reg <= count_reg - WIDTH'(1);
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// PS/2 keyboard + joystick merge for up to two players with rotation remap and
// coin stretching; every output is registered.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS = 2,
    parameter int          NUM_BUTTONS = 2,
    parameter logic [15:0] COIN_PULSE  = 16'd48000
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic [10:0]                      ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]        joystick,
    input  logic                             rotate,
    input  logic                             rotate_ccw,
    output logic [NUM_PLAYERS-1:0]           p_up,
    output logic [NUM_PLAYERS-1:0]           p_down,
    output logic [NUM_PLAYERS-1:0]           p_left,
    output logic [NUM_PLAYERS-1:0]           p_right,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] p_fire,
    output logic [NUM_PLAYERS-1:0]           p_start,
    output logic [NUM_PLAYERS-1:0]           p_coin
);

    localparam int JOY_START = joy_aux_idx(NUM_BUTTONS, 1'b0);
    localparam int JOY_COIN  = joy_aux_idx(NUM_BUTTONS, 1'b1);

    logic                              toggle_reg;
    logic                              armed_reg;
    logic                              key_event;
    logic [NUM_SLOTS*NUM_PLAYERS-1:0]  key_reg;

    function automatic logic slot_used(input int s);
        return !(s >= JOY_BTN0 + NUM_BUTTONS && s < JOY_BTN0 + 4);
    endfunction

    // armed_reg keeps the first post-reset clock from treating a stale toggle as an event.
    assign key_event = armed_reg && (ps2_key[10] != toggle_reg);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            toggle_reg <= 1'b0;
            armed_reg  <= 1'b0;
            key_reg    <= '0;
        end else begin
            armed_reg  <= 1'b1;
            toggle_reg <= ps2_key[10];
            if (key_event) begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        if (slot_used(s) && ps2_key[8:0] == key_code(p, s))
                            key_reg[p*NUM_SLOTS+s] <= ps2_key[9];
                    end
                end
            end
        end
    end

    logic [NUM_PLAYERS-1:0]             up_next, down_next, left_next, right_next, start_next;
    logic [NUM_BUTTONS*NUM_PLAYERS-1:0] fire_next;
    logic [NUM_PLAYERS-1:0]             raw_coin;

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic r_up, r_down, r_left, r_right;

            assign r_right = key_reg[NUM_SLOTS*gi+JOY_RIGHT] | joystick[16*gi+JOY_RIGHT];
            assign r_left  = key_reg[NUM_SLOTS*gi+JOY_LEFT]  | joystick[16*gi+JOY_LEFT];
            assign r_down  = key_reg[NUM_SLOTS*gi+JOY_DOWN]  | joystick[16*gi+JOY_DOWN];
            assign r_up    = key_reg[NUM_SLOTS*gi+JOY_UP]    | joystick[16*gi+JOY_UP];

            assign up_next[gi]    = !rotate ? r_up    : (rotate_ccw ? r_right : r_left);
            assign down_next[gi]  = !rotate ? r_down  : (rotate_ccw ? r_left  : r_right);
            assign left_next[gi]  = !rotate ? r_left  : (rotate_ccw ? r_up    : r_down);
            assign right_next[gi] = !rotate ? r_right : (rotate_ccw ? r_down  : r_up);

            for (genvar gj = 0; gj < NUM_BUTTONS; gj++) begin : g_fire
                assign fire_next[NUM_BUTTONS*gi+gj] = key_reg[NUM_SLOTS*gi+JOY_BTN0+gj]
                                                    | joystick[16*gi+JOY_BTN0+gj];
            end

            assign start_next[gi] = key_reg[NUM_SLOTS*gi+SLOT_START] | joystick[16*gi+JOY_START];
            assign raw_coin[gi]   = key_reg[NUM_SLOTS*gi+SLOT_COIN]  | joystick[16*gi+JOY_COIN];

            coin_stretch #(
                .WIDTH (16),
                .PULSE (COIN_PULSE)
            ) u_coin (
                .clk_sys (clk_sys),
                .reset   (reset),
                .in      (raw_coin[gi]),
                .out     (p_coin[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            p_up    <= '0;
            p_down  <= '0;
            p_left  <= '0;
            p_right <= '0;
            p_fire  <= '0;
            p_start <= '0;
        end else begin
            p_up    <= up_next;
            p_down  <= down_next;
            p_left  <= left_next;
            p_right <= right_next;
            p_fire  <= fire_next;
            p_start <= start_next;
        end
    end

    // Upper joystick bits and unused fire slots are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{joystick, key_reg};

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised replacement for the per-core hand-written PS/2 decode and joystick OR logic.
- Decodes MiSTer ps2_key events into held key state for up to 2 players, with a fixed MAME/JPAC keymap.
- Merges keyboard state with joystick words and applies screen-rotation remapping.
- Stretches coin pulses to a guaranteed minimum width; outputs feed the game core's player inputs directly.

Parameters:
- NUM_PLAYERS, 2, number of player channels (1 or 2).
- NUM_BUTTONS, 2, fire buttons per player (1..4).
- COIN_PULSE, 16'd48000, minimum coin output high time in clk_sys cycles (1 ms at 48 MHz); must be ≥1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- joystick  in  16*NUM_PLAYERS  MiSTer joystick words, player p at [16p+15:16p]
- rotate  in  1  1 = remap directions for a rotated display
- rotate_ccw  in  1  rotation sense when rotate = 1
- p_up, p_down, p_left, p_right  out  NUM_PLAYERS  per-player directions
- p_fire  out  NUM_BUTTONS*NUM_PLAYERS  player p fire buttons at [NUM_BUTTONS*p +: NUM_BUTTONS]
- p_start  out  NUM_PLAYERS  start buttons
- p_coin  out  NUM_PLAYERS  stretched coin signals

Behaviour:
- Reset (async assert, sync release to clk_sys): all outputs 0, all key state 0, coin counters 0. The stored old toggle value loads ps2_key[10] on the first clock after reset release, so no spurious event is generated.
- Event detect: an event fires when ps2_key[10] differs from its registered copy.
- On an event, the held key bit for code {ps2_key[8], ps2_key[7:0]} is set to ps2_key[9]. Unmapped codes are ignored.
- Keymap, 9-bit codes:
  - P1: up 0x175, down 0x172, left 0x16B, right 0x174; fire0 0x014, fire1 0x011, fire2 0x029, fire3 0x012; start 0x016; coin 0x02E.
  - P2: up 0x02D, down 0x02B, left 0x023, right 0x034; fire0 0x01C, fire1 0x01B, fire2 0x015, fire3 0x01D; start 0x01E; coin 0x036.
  - Keys for fire buttons ≥ NUM_BUTTONS, and P2 keys when NUM_PLAYERS = 1, are ignored.
- Joystick word fields: bit0 right, bit1 left, bit2 down, bit3 up, bits 4..4+NUM_BUTTONS-1 fires, then start, then coin.
- Raw signal per input = key state OR matching joystick bit.
- Rotation, applied to the raw directions:
  - rotate = 0: pass-through.
  - rotate = 1, rotate_ccw = 0: up←left, down←right, left←down, right←up.
  - rotate = 1, rotate_ccw = 1: up←right, down←left, left←up, right←down.
- All outputs are registered.
  - Latency: joystick change to output = 1 clock.
  - Latency: ps2_key toggle to output = 2 clocks (event register, then output register).
- Coin stretch, per player:
  - On a rising edge of raw coin, the counter loads COIN_PULSE-1.
  - p_coin = (counter ≠ 0) OR raw coin, OR the cycle of the rising edge itself. Minimum high time is COIN_PULSE cycles.
  - The counter decrements to 0 and saturates there.
  - A rising edge while the counter is running reloads it.
- Simultaneous key press and joystick on the same input: OR'd, no conflict.
- rotate changes: take effect on the next output register update. No key-state reset.
- Reset mid-pulse: p_coin drops immediately (async).

Decomposition:
- Package arcade_input_pkg:
  - 9-bit keycode localparams (KEY_P1_UP…KEY_P2_COIN).
  - Joystick bit-index constants (JOY_RIGHT…JOY_BTN0).
  - A function returning the start/coin bit index for a given NUM_BUTTONS.
- Sub-module coin_stretch (params WIDTH, PULSE; ports clk_sys, reset, in, out), instantiated once per player.

Test Plan:
- Reset release with ps2_key[10] = 1 → no key state change; all outputs 0 for 10 clocks.
- Toggle ps2_key to {1, pressed=1, 0x175}, then later {0, pressed=0, 0x175} → p_up[0] = 1 exactly 2 clocks after the first toggle, p_up[0] = 0 2 clocks after the second; 0x075 (non-extended) leaves p_up unchanged.
- joystick[1] = 1 (P1 left) with rotate = 1, rotate_ccw = 0 → p_up[0] = 1 after 1 clock; with rotate_ccw = 1 → p_down[0] = 1; with rotate = 0 → p_left[0] = 1.
- COIN_PULSE = 8, single-cycle joystick coin pulse on P2 → p_coin[1] high exactly 8 clocks. Holding the coin for 20 clocks → high for 20 clocks. A second edge at clock 5 of the pulse → high until clock 13.
- NUM_BUTTONS = 2, key 0x029 (fire2) pressed → p_fire unchanged. Key 0x011 → p_fire[1] = 1. P2 key 0x01C → p_fire[2] = 1.
- Assert reset while p_coin[0] and p_fire[0] are high → both 0 in the same cycle, before any clock edge. After release, the key must be pressed again to reassert.
